// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path and the UART readout side:
// FSM state encoding, default buffer geometry and the RGB565 -> RGB332 packer.
package cam_pkg;

    localparam int CAM_ADDR_W    = 15;
    localparam int CAM_MAX_WORDS = 19200;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VS_HI,
        ST_WAIT_VS_LO,
        ST_CAPTURE
    } cam_state_t;

    // hi = {R4..R0, G5..G3}, lo = {G2..G0, B4..B0}; keep the top bits of each
    // colour channel: 3 of red, 3 of green, 2 of blue.
    function automatic logic [7:0] rgb565_to_332(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:5], hi[2:0], lo[4:3]};
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Brings the asynchronous camera bus into the clk domain (two flops per bit)
// and turns the synchronised PCLK into a one-cycle rising-edge pulse.
module cam_sync_edge (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cam_data,
    input  logic       cam_pclk,
    input  logic       cam_href,
    input  logic       cam_vsync,
    output logic [7:0] data,
    output logic       href,
    output logic       vsync,
    output logic       pe
);

    logic [10:0] meta;
    logic [10:0] sync;
    logic        pclk_d;

    // Two-stage synchroniser for all 11 camera bits plus the PCLK history flop.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= '0;
            sync   <= '0;
            pclk_d <= 1'b0;
        end else begin
            meta   <= {cam_pclk, cam_href, cam_vsync, cam_data};
            sync   <= meta;
            pclk_d <= sync[10];
        end
    end

    assign pe    = sync[10] & ~pclk_d;
    assign href  = sync[9];
    assign vsync = sync[8];
    assign data  = sync[7:0];

endmodule

// File: rtl/cam_capture_decim.sv
// Captures one full RGB565 frame, decimates it by H_DECIM x V_DECIM, packs
// each kept pixel to RGB332 and issues linear write strobes to the buffer.
module cam_capture_decim
    import cam_pkg::*;
#(
    parameter int ADDR_W    = CAM_ADDR_W,
    parameter int H_DECIM   = 4,
    parameter int V_DECIM   = 4,
    parameter int MAX_WORDS = CAM_MAX_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic [7:0]        cam_data,
    input  logic              cam_pclk,
    input  logic              cam_href,
    input  logic              cam_vsync,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] word_count
);

    // Decimation factors are powers of two, so "x % N == 0" is a mask test.
    localparam logic [15:0]       H_MASK  = 16'(H_DECIM - 1);
    localparam logic [15:0]       V_MASK  = 16'(V_DECIM - 1);
    localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(MAX_WORDS);

    logic [7:0] s_data;
    logic       s_href;
    logic       s_vsync;
    logic       pe;

    cam_sync_edge u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .cam_data  (cam_data),
        .cam_pclk  (cam_pclk),
        .cam_href  (cam_href),
        .cam_vsync (cam_vsync),
        .data      (s_data),
        .href      (s_href),
        .vsync     (s_vsync),
        .pe        (pe)
    );

    cam_state_t  state;
    logic [15:0] line_cnt;
    logic [15:0] pix_cnt;
    logic        phase;
    logic        href_prev;
    logic [7:0]  hi_byte;
    logic        keep;

    assign keep = ((pix_cnt & H_MASK) == 16'd0) && ((line_cnt & V_MASK) == 16'd0);

    // Capture FSM with registered strobes, counters and write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            line_cnt   <= '0;
            pix_cnt    <= '0;
            phase      <= 1'b0;
            href_prev  <= 1'b0;
            hi_byte    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            // NOTE: strobes default low every cycle so they can only ever be
            // one clock wide; the branches below raise them when needed.
            wr_en <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state      <= ST_WAIT_VS_HI;
                        busy       <= 1'b1;
                        word_count <= '0;
                        overflow   <= 1'b0;
                        wr_addr    <= '0;
                    end
                end
                // Wait for inter-frame VSYNC so capture never starts mid-frame.
                ST_WAIT_VS_HI: begin
                    if (pe && s_vsync) state <= ST_WAIT_VS_LO;
                end
                ST_WAIT_VS_LO: begin
                    if (pe && !s_vsync) begin
                        state     <= ST_CAPTURE;
                        line_cnt  <= '0;
                        pix_cnt   <= '0;
                        phase     <= 1'b0;
                        href_prev <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (pe) begin
                        if (s_vsync) begin
                            // Frame end wins over any byte in the same sample,
                            // so a partial pixel is dropped and done never
                            // coincides with a write.
                            state <= ST_IDLE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            href_prev <= s_href;
                            if (s_href) begin
                                if (!phase) begin
                                    hi_byte <= s_data;
                                    phase   <= 1'b1;
                                end else begin
                                    phase   <= 1'b0;
                                    pix_cnt <= pix_cnt + 16'd1;
                                    if (keep) begin
                                        if (word_count == MAX_CNT) begin
                                            overflow <= 1'b1;
                                        end else begin
                                            wr_en      <= 1'b1;
                                            wr_addr    <= word_count;
                                            wr_data    <= rgb565_to_332(hi_byte, s_data);
                                            word_count <= word_count + 1'b1;
                                        end
                                    end
                                end
                            end else if (href_prev) begin
                                // End of line: an odd trailing byte is discarded.
                                line_cnt <= line_cnt + 16'd1;
                                pix_cnt  <= '0;
                                phase    <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture_decim.sv
// Randomised bench for cam_capture_decim: a camera model plays frames, a
// frame-level reference model queues expected writes, and a monitor checks
// every write strobe of two instances (default depth and a 5-byte buffer).
module tb_cam_capture_decim;

    localparam int HD    = 4;
    localparam int VD    = 4;
    localparam int MAXW  = 19200;
    localparam int MAXW_O = 5;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm, arm_o;
    logic [7:0]  cam_data;
    logic        cam_pclk, cam_href, cam_vsync;

    logic        wr_en, busy, done, overflow;
    logic [14:0] wr_addr, word_count;
    logic [7:0]  wr_data;
    logic        wr_en_o, busy_o, done_o, overflow_o;
    logic [14:0] wr_addr_o, word_count_o;
    logic [7:0]  wr_data_o;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int done_cnt_o = 0;
    int cur_line = -1;
    logic prev_wr = 1'b0;
    logic prev_wr_o = 1'b0;

    exp_t q[$];
    exp_t q_o[$];

    logic [7:0] fb [16][64];
    int         flen [16];
    int         nlines;

    always #5 clk = ~clk;

    cam_capture_decim #(.ADDR_W(15), .H_DECIM(HD), .V_DECIM(VD), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .cam_data(cam_data), .cam_pclk(cam_pclk),
        .cam_href(cam_href), .cam_vsync(cam_vsync), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .overflow(overflow),
        .word_count(word_count)
    );

    cam_capture_decim #(.ADDR_W(15), .H_DECIM(HD), .V_DECIM(VD), .MAX_WORDS(MAXW_O)) dut_o (
        .clk(clk), .rst_n(rst_n), .arm(arm_o), .cam_data(cam_data), .cam_pclk(cam_pclk),
        .cam_href(cam_href), .cam_vsync(cam_vsync), .wr_en(wr_en_o), .wr_addr(wr_addr_o),
        .wr_data(wr_data_o), .busy(busy_o), .done(done_o), .overflow(overflow_o),
        .word_count(word_count_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference colour reduction from the 16-bit pixel value.
    function automatic int to_332(input int pix);
        int r5, g6, b5;
        r5 = (pix >> 11) & 31;
        g6 = (pix >> 5) & 63;
        b5 = pix & 31;
        return ((r5 / 4) * 32) + ((g6 / 8) * 4) + (b5 / 8);
    endfunction

    // Expected writes for the frame in fb (lines below line_limit only).
    task automatic model(input int max_w, input int line_limit, input bit to_o, output int kept);
        exp_t e;
        kept = 0;
        for (int l = 0; l < nlines && l < line_limit; l++) begin
            for (int p = 0; p < flen[l] / 2; p++) begin
                if ((p % HD) == 0 && (l % VD) == 0) begin
                    if (kept < max_w) begin
                        e.addr = kept;
                        e.data = to_332({16'd0, fb[l][2*p], fb[l][2*p+1]});
                        if (to_o) q_o.push_back(e);
                        else      q.push_back(e);
                    end
                    kept++;
                end
            end
        end
    endtask

    task automatic gen_random(input int nl, input int nb_min, input int nb_max);
        nlines = nl;
        for (int l = 0; l < nl; l++) begin
            flen[l] = $urandom_range(nb_max, nb_min);
            for (int b = 0; b < 64; b++) fb[l][b] = 8'($urandom);
        end
    endtask

    task automatic gen_const(input int nl, input int nb, input logic [15:0] pix);
        nlines = nl;
        for (int l = 0; l < nl; l++) begin
            flen[l] = nb;
            for (int p = 0; p < 32; p++) begin
                fb[l][2*p]   = pix[15:8];
                fb[l][2*p+1] = pix[7:0];
            end
        end
    endtask

    task automatic set_pix(input int l, input int p, input logic [15:0] pix);
        fb[l][2*p]   = pix[15:8];
        fb[l][2*p+1] = pix[7:0];
    endtask

    // One camera pixel clock: inputs change while PCLK is low (period 8 clk).
    task automatic pclk_tick();
        #40 cam_pclk = 1'b1;
        #40 cam_pclk = 1'b0;
    endtask

    task automatic play_lines();
        for (int l = 0; l < nlines; l++) begin
            cur_line = l;
            cam_href = 1'b1;
            for (int b = 0; b < flen[l]; b++) begin
                cam_data = fb[l][b];
                pclk_tick();
            end
            cam_href = 1'b0;
            repeat (3) begin
                cam_data = 8'($urandom);
                pclk_tick();
            end
        end
    endtask

    task automatic play_frame();
        cur_line  = -1;
        cam_href  = 1'b0;
        cam_vsync = 1'b1;
        repeat (3) pclk_tick();
        cam_vsync = 1'b0;
        repeat (2) pclk_tick();
        play_lines();
        cam_vsync = 1'b1;
        repeat (3) pclk_tick();
    endtask

    task automatic do_arm();
        @(posedge clk); #1 arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
        check("busy_after_arm", 32'(busy), 32'd1);
    endtask

    task automatic finish_frame(input string tag, input int d0, input int exp_wc);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check({tag, "_done_cnt"}, done_cnt - d0, 1);
        check({tag, "_word_count"}, 32'(word_count), exp_wc);
        check({tag, "_pending"}, q.size(), 0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    // Monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        exp_t e;
        if (done)   done_cnt++;
        if (done_o) done_cnt_o++;
        if (wr_en) begin
            check("wr_expected", 32'(q.size() != 0), 32'd1);
            check("wr_single", 32'(prev_wr | done), 32'd0);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("wr_addr", 32'(wr_addr), e.addr);
                check("wr_data", 32'(wr_data), e.data);
            end
        end
        if (wr_en_o) begin
            check("wr_o_expected", 32'(q_o.size() != 0), 32'd1);
            check("wr_o_single", 32'(prev_wr_o | done_o), 32'd0);
            if (q_o.size() != 0) begin
                e = q_o.pop_front();
                check("wr_o_addr", 32'(wr_addr_o), e.addr);
                check("wr_o_data", 32'(wr_data_o), e.data);
            end
        end
        prev_wr   = wr_en;
        prev_wr_o = wr_en_o;
    end

    initial begin
        int kept, d0;
        rst_n     = 1'b0;
        arm       = 1'b0;
        arm_o     = 1'b0;
        cam_data  = 8'h00;
        cam_pclk  = 1'b0;
        cam_href  = 1'b0;
        cam_vsync = 1'b1;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Basic frame: solid red, 8 lines x 16 pixels.
        gen_const(8, 32, 16'hF800);
        model(MAXW, 99, 1'b0, kept);
        d0 = done_cnt;
        do_arm();
        play_frame();
        finish_frame("basic", d0, kept);

        // Colour mapping on kept positions of line 0.
        gen_random(8, 32, 32);
        set_pix(0, 0, 16'h07E0);
        set_pix(0, 4, 16'h001F);
        set_pix(0, 8, 16'hFFFF);
        model(MAXW, 99, 1'b0, kept);
        d0 = done_cnt;
        do_arm();
        play_frame();
        finish_frame("colour", d0, kept);

        // Random frames, including odd byte counts per line.
        for (int f = 0; f < 3; f++) begin
            gen_random($urandom_range(10, 5), 1, 40);
            model(MAXW, 99, 1'b0, kept);
            d0 = done_cnt;
            do_arm();
            play_frame();
            finish_frame("random", d0, kept);
        end

        // Odd HREF: 9-byte lines on kept rows must not shift later pixels.
        gen_random(9, 30, 30);
        flen[0] = 9;
        flen[4] = 9;
        flen[3] = 7;
        model(MAXW, 99, 1'b0, kept);
        d0 = done_cnt;
        do_arm();
        play_frame();
        finish_frame("odd_href", d0, kept);

        // Partial-frame rejection: armed mid-frame, nothing written until the
        // next full frame, which starts at address 0.
        cam_vsync = 1'b0;
        repeat (2) pclk_tick();
        gen_random(6, 10, 30);
        fork
            play_lines();
            begin
                wait (cur_line == 1);
                do_arm();
            end
        join
        @(negedge clk);
        check("partial_busy", 32'(busy), 32'd1);
        check("partial_wc", 32'(word_count), 32'd0);
        gen_random(8, 20, 40);
        model(MAXW, 99, 1'b0, kept);
        d0 = done_cnt;
        play_frame();
        finish_frame("partial", d0, kept);

        // Second arm during CAPTURE is ignored.
        gen_random(9, 24, 40);
        model(MAXW, 99, 1'b0, kept);
        d0 = done_cnt;
        do_arm();
        cur_line = -1;
        fork
            play_frame();
            begin
                wait (cur_line == 5);
                @(posedge clk); #1 arm = 1'b1;
                @(posedge clk); #1 arm = 1'b0;
            end
        join
        finish_frame("rearm", d0, kept);

        // Reset during line 2: line 0 already written, nothing afterwards.
        gen_random(8, 24, 40);
        model(MAXW, 2, 1'b0, kept);
        d0 = done_cnt;
        do_arm();
        cur_line = -1;
        fork
            play_frame();
            begin
                wait (cur_line == 2);
                repeat (20) @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("mid_rst_wr_en", 32'(wr_en), 32'd0);
                check("mid_rst_busy", 32'(busy), 32'd0);
                check("mid_rst_wc", 32'(word_count), 32'd0);
                repeat (30) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("post_rst_done", done_cnt - d0, 0);
        check("post_rst_pending", q.size(), 0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_wc", 32'(word_count), 32'd0);

        // Overflow on the 5-byte instance: 8 kept pixels, 5 written.
        gen_random(8, 32, 32);
        model(MAXW_O, 99, 1'b1, kept);
        d0 = done_cnt_o;
        @(posedge clk); #1 arm_o = 1'b1;
        @(posedge clk); #1 arm_o = 1'b0;
        play_frame();
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("ovf_done_cnt", done_cnt_o - d0, 1);
        check("ovf_word_count", 32'(word_count_o), 32'd5);
        check("ovf_flag", 32'(overflow_o), 32'd1);
        check("ovf_pending", q_o.size(), 0);
        @(posedge clk); #1 arm_o = 1'b1;
        @(posedge clk); #1 arm_o = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 32'(overflow_o), 32'd0);
        check("ovf_rearm_busy", 32'(busy_o), 32'd1);
        check("ovf_rearm_wc", 32'(word_count_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
